// File: rtl/pill_score_display.sv
// pill_score_display: counts pills eaten by Pac-Man (8-bit, wraps at 256) and shows
// the running total on three active-low 7-segment digits (hundreds/tens/ones).
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zeros on the hundreds and tens
// digits; without it all three digits are always lit (e.g. "007").
module pill_score_display #(
  parameter logic [3:0] PILL_CODE = 4'b0010
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [3:0] collision_type,
  output logic [6:0] hex1,
  output logic [6:0] hex2,
  output logic [6:0] hex3
);

  // The double-dabble stage below is sized for exactly 0..255.
  localparam int CNT_W = 8;

  logic [CNT_W-1:0] count;
  logic [11:0]      bcd;
  logic [3:0]       hundreds;
  logic [3:0]       tens;
  logic [3:0]       ones;
  logic             en_hundreds;
  logic             en_tens;

  // Hex-to-7-segment decoder, segments {g,f,e,d,c,b,a}, active-low; blank when disabled.
  function automatic logic [6:0] seg_decode(input logic [3:0] digit, input logic enable);
    logic [6:0] seg;
    case (digit)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return enable ? seg : 7'b1111111;
  endfunction

  // Pill counter: synchronous active-low reset wins over a pill in the same cycle.
  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      count <= '0;
    end else if (collision_type == PILL_CODE) begin
      count <= count + 1'b1;
    end
  end

  // Double-dabble binary-to-BCD conversion of the current count.
  always_comb begin
    bcd = '0;
    for (int i = CNT_W - 1; i >= 0; i--) begin
      if (bcd[3:0] >= 4'd5) begin
        bcd[3:0] = bcd[3:0] + 4'd3;
      end
      if (bcd[7:4] >= 4'd5) begin
        bcd[7:4] = bcd[7:4] + 4'd3;
      end
      if (bcd[11:8] >= 4'd5) begin
        bcd[11:8] = bcd[11:8] + 4'd3;
      end
      bcd = {bcd[10:0], count[i]};
    end
  end

  assign hundreds = bcd[11:8];
  assign tens     = bcd[7:4];
  assign ones     = bcd[3:0];

`ifdef LEADING_ZERO_BLANK_EN
  assign en_hundreds = (hundreds != 4'd0);
  assign en_tens     = (hundreds != 4'd0) || (tens != 4'd0);
`else
  assign en_hundreds = 1'b1;
  assign en_tens     = 1'b1;
`endif

  assign hex1 = seg_decode(hundreds, en_hundreds);
  assign hex2 = seg_decode(tens, en_tens);
  assign hex3 = seg_decode(ones, 1'b1);

endmodule

// File: tb/tb_pill_score_display.sv
// tb_pill_score_display: directed vector table plus hand-written long sequences
// (137 pills, run up to 255, wrap to 0, reset with pill held) for pill_score_display.
module tb_pill_score_display;

  logic       CLOCK_50;
  logic       reset;
  logic [3:0] collision_type;
  logic [6:0] hex1;
  logic [6:0] hex2;
  logic [6:0] hex3;

  int testsRun;
  int testsFailed;
  int modelCount;

  typedef struct {
    logic       rst;
    logic [3:0] code;
    int         expHundreds;
    int         expTens;
    int         expOnes;
  } vector_t;

  vector_t vectors [13];

  pill_score_display dut (
    .CLOCK_50       (CLOCK_50),
    .reset          (reset),
    .collision_type (collision_type),
    .hex1           (hex1),
    .hex2           (hex2),
    .hex3           (hex3)
  );

  // 50 MHz-style free-running clock
  initial begin
    CLOCK_50 = 1'b0;
    forever #10 CLOCK_50 = ~CLOCK_50;
  end

  // Reference segment patterns for decimal digits, active-low {g,f,e,d,c,b,a}
  function automatic logic [6:0] refSeg(input int digit);
    case (digit)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Drive inputs away from the edge, let one rising edge pass, settle before sampling
  task automatic applyStimulus(input logic rst, input logic [3:0] code);
    @(negedge CLOCK_50);
    reset = rst;
    collision_type = code;
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic checkOne(input string name, input logic [6:0] actual, input logic [6:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
    end
  endtask

  // Compare all three displays against a decimal value, applying leading-zero blanking if built in
  task automatic checkOutput(input string name, input int h, input int t, input int o);
    logic [6:0] eh;
    logic [6:0] et;
    eh = refSeg(h);
    et = refSeg(t);
`ifdef LEADING_ZERO_BLANK_EN
    if (h == 0) eh = 7'b1111111;
    if (h == 0 && t == 0) et = 7'b1111111;
`endif
    checkOne({name, " hex1"}, hex1, eh);
    checkOne({name, " hex2"}, hex2, et);
    checkOne({name, " hex3"}, hex3, refSeg(o));
  endtask

  task automatic checkValue(input string name, input int value);
    checkOutput(name, value / 100, (value / 10) % 10, value % 10);
  endtask

  initial begin
    testsRun = 0;
    testsFailed = 0;
    reset = 1'b0;
    collision_type = 4'b0000;

    vectors[0]  = '{1'b0, 4'b0000, 0, 0, 0};
    vectors[1]  = '{1'b0, 4'b0010, 0, 0, 0};
    vectors[2]  = '{1'b1, 4'b0000, 0, 0, 0};
    vectors[3]  = '{1'b1, 4'b0010, 0, 0, 1};
    vectors[4]  = '{1'b1, 4'b0110, 0, 0, 1};
    vectors[5]  = '{1'b1, 4'b0010, 0, 0, 2};
    vectors[6]  = '{1'b1, 4'b0010, 0, 0, 3};
    vectors[7]  = '{1'b1, 4'b0011, 0, 0, 3};
    vectors[8]  = '{1'b1, 4'b1111, 0, 0, 3};
    vectors[9]  = '{1'b1, 4'b0010, 0, 0, 4};
    vectors[10] = '{1'b1, 4'b1010, 0, 0, 4};
    vectors[11] = '{1'b0, 4'b0110, 0, 0, 0};
    vectors[12] = '{1'b1, 4'b0010, 0, 0, 1};

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vectors[i].rst, vectors[i].code);
      checkOutput($sformatf("vec%0d", i), vectors[i].expHundreds, vectors[i].expTens, vectors[i].expOnes);
    end

    // Fresh reset, then 137 consecutive pills
    applyStimulus(1'b0, 4'b0000);
    checkOutput("reset", 0, 0, 0);
    modelCount = 0;
    for (int i = 0; i < 137; i++) begin
      applyStimulus(1'b1, 4'b0010);
      modelCount = (modelCount + 1) % 256;
      checkValue($sformatf("count%0d", modelCount), modelCount);
    end
    checkOne("c137 hex1", hex1, 7'b1111001);
    checkOne("c137 hex2", hex2, 7'b0110000);
    checkOne("c137 hex3", hex3, 7'b1111000);

    // Continue to 255, then one more wraps to 0
    for (int i = 0; i < 118; i++) begin
      applyStimulus(1'b1, 4'b0010);
      modelCount = (modelCount + 1) % 256;
      checkValue($sformatf("count%0d", modelCount), modelCount);
    end
    checkOne("c255 hex1", hex1, 7'b0100100);
    checkOne("c255 hex2", hex2, 7'b0010010);
    checkOne("c255 hex3", hex3, 7'b0010010);
    applyStimulus(1'b1, 4'b0010);
    checkOutput("wrap", 0, 0, 0);

    // Mid-count reset with the pill code held: reset wins, then counting resumes
    for (int i = 0; i < 40; i++) applyStimulus(1'b1, 4'b0010);
    checkOutput("count40", 0, 4, 0);
    applyStimulus(1'b0, 4'b0010);
    checkOutput("reset held pill", 0, 0, 0);
    applyStimulus(1'b0, 4'b0010);
    checkOutput("reset held pill 2", 0, 0, 0);
    applyStimulus(1'b1, 4'b0010);
    checkOutput("resume", 0, 0, 1);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 4'b0010);
    checkOutput("count7", 0, 0, 7);
    applyStimulus(1'b1, 4'b0110);
    checkOutput("hold7", 0, 0, 7);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
